// File: rtl/dmem_lsu.sv
// Load/store unit between the core memory stage and a word-wide data memory.
// One request at a time; sub-word stores go through a read-modify-write pass.
module dmem_lsu #(
    parameter logic [31:0] ADDR_LIMIT   = 32'h0000_00FF,
    parameter bit          MISALIGN_ERR = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_WRITE,
        S_RESP
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [15:0] r_wdata;
    logic [31:0] r_mem_wd;
    logic [31:0] r_rdata;
    logic        r_err;

    logic [31:0] w_addr_eff;
    logic [1:0]  w_span;
    logic [32:0] w_last_byte;
    logic        w_misalign;
    logic        w_err;
    logic [31:0] w_word_addr;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_data;
    logic [31:0] w_merged;

    // Request decode at accept: the range check runs in 33 bits so an access
    // that wraps past 32'hFFFF_FFFF is still flagged.
    always_comb begin
        w_span     = 2'd3;
        w_misalign = 1'b0;
        w_addr_eff = req_addr;
        case (req_size)
            SZ_BYTE: w_span = 2'd0;
            SZ_HALF: begin
                w_span     = 2'd1;
                w_misalign = req_addr[0];
            end
            SZ_WORD: w_misalign = (req_addr[1:0] != 2'b00);
            default: w_span = 2'd3;
        endcase
        if (!MISALIGN_ERR) begin
            if (req_size == SZ_HALF) w_addr_eff[0]   = 1'b0;
            if (req_size == SZ_WORD) w_addr_eff[1:0] = 2'b00;
        end
        w_last_byte = {1'b0, w_addr_eff} + {31'b0, w_span};
        w_err = (req_size == SZ_BAD) || (MISALIGN_ERR && w_misalign) ||
                (w_last_byte > {1'b0, ADDR_LIMIT});
    end

    assign w_word_addr = {r_addr[31:2], 2'b00};

    // Little-endian lane selection for load extraction and store merge.
    always_comb begin
        w_ld_byte = mem_rd[{r_addr[1:0], 3'b000} +: 8];
        w_ld_half = mem_rd[{r_addr[1], 4'b0000} +: 16];
        case (r_size)
            SZ_BYTE: w_ld_data = {{24{w_ld_byte[7] & ~r_unsigned}}, w_ld_byte};
            SZ_HALF: w_ld_data = {{16{w_ld_half[15] & ~r_unsigned}}, w_ld_half};
            default: w_ld_data = mem_rd;
        endcase
        w_merged = mem_rd;
        if (r_size == SZ_BYTE) w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        else                   w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        w_next     = r_state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'd0;
        resp_err   = 1'b0;
        mem_we     = 1'b0;
        mem_a      = 32'd0;
        mem_wd     = 32'd0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_err)                  w_next = S_RESP;
                    else if (!req_we)           w_next = S_LOAD;
                    else if (req_size == SZ_WORD) w_next = S_WRITE;
                    else                        w_next = S_RMW_RD;
                end
            end
            S_LOAD: begin
                mem_a  = w_word_addr;
                w_next = S_RESP;
            end
            S_RMW_RD: begin
                mem_a  = w_word_addr;
                w_next = S_WRITE;
            end
            S_WRITE: begin
                mem_we = 1'b1;
                mem_a  = w_word_addr;
                mem_wd = r_mem_wd;
                w_next = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = r_rdata;
                resp_err   = r_err;
                if (resp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_addr     <= 32'd0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_wdata    <= 16'd0;
            r_mem_wd   <= 32'd0;
            r_rdata    <= 32'd0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr     <= w_addr_eff;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_wdata    <= req_wdata[15:0];
                        r_mem_wd   <= req_wdata;
                        r_rdata    <= 32'd0;
                        r_err      <= w_err;
                    end
                end
                S_LOAD:   r_rdata  <= w_ld_data;
                S_RMW_RD: r_mem_wd <= w_merged;
                default: ;
            endcase
        end
    end

endmodule
